// File: rtl/systolic_array_nxn_if.sv
// rtl/systolic_array_nxn_if.sv - beat/result bus of the NxN systolic multiplier
interface systolic_array_nxn_if #(
    parameter int N     = 4,
    parameter int WIDTH = 16
);
    logic                   start;
    logic                   in_valid;
    logic                   in_ready;
    logic                   in_last;
    logic [N*WIDTH-1:0]     in_west;
    logic [N*WIDTH-1:0]     in_north;
    logic                   busy;
    logic                   done;
    logic [N*N*WIDTH-1:0]   out;

    modport master (
        output start, in_valid, in_last, in_west, in_north,
        input  in_ready, busy, done, out
    );

    modport slave (
        input  start, in_valid, in_last, in_west, in_north,
        output in_ready, busy, done, out
    );
endinterface

// File: rtl/systolic_array_nxn.sv
// rtl/systolic_array_nxn.sv - NxN output-stationary systolic matmul; SYSTOLIC_SATURATE_EN clamps result words
module systolic_array_nxn #(
    parameter int WIDTH      = 16,
    parameter int FRAC_WIDTH = 8,
    parameter int N          = 4,
    parameter int ACC_GUARD  = 8
) (
    input  logic                clk,
    input  logic                rst,
    systolic_array_nxn_if.slave bus
);
    localparam int ACC_W = 2*WIDTH + ACC_GUARD;
    localparam int CW    = $clog2(2*N);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(2*N-2);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           ready_q, busy_q, done_q;
    logic           start_take, accept, drain_end;
    logic [N*N*WIDTH-1:0] out_w;

`ifdef SYSTOLIC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = $signed({{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SAT_MIN = $signed({{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}});
`endif

    function automatic logic [WIDTH-1:0] to_out(input logic signed [ACC_W-1:0] a);
`ifdef SYSTOLIC_SATURATE_EN
        logic signed [ACC_W-1:0] s;
        s = a >>> FRAC_WIDTH;
        if (s > SAT_MAX)      to_out = SAT_MAX[WIDTH-1:0];
        else if (s < SAT_MIN) to_out = SAT_MIN[WIDTH-1:0];
        else                  to_out = s[WIDTH-1:0];
`else
        to_out = WIDTH'(a >>> FRAC_WIDTH);
`endif
    endfunction

    assign start_take = bus.start && (state == S_IDLE || state == S_DONE);
    assign accept     = bus.in_valid && ready_q;
    assign drain_end  = (state == S_DRAIN) && (cnt == DRAIN_LAST);

    // Drain counts the 2N-1 edges the last beat needs to reach PE[N-1][N-1] and land in out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) begin
                    state   <= S_LOAD;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b1;
                end
                S_LOAD: if (accept && bus.in_last) begin
                    state   <= S_DRAIN;
                    ready_q <= 1'b0;
                    cnt     <= '0;
                end
                S_DRAIN: if (drain_end) begin
                    state  <= S_DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                S_DONE: if (bus.start) begin
                    state   <= S_LOAD;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b1;
                end else begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready = ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.out      = out_w;

    logic signed [WIDTH-1:0] w_sk [N];
    logic signed [WIDTH-1:0] n_sk [N];
    logic                    wv_sk [N];
    logic                    nv_sk [N];

    // Lane k of both edges is delayed k cycles so operands meet at PE[i][j] after i+j hops.
    for (genvar gl = 0; gl < N; gl++) begin : g_skew
        if (gl == 0) begin : g_direct
            assign w_sk[0]  = bus.in_west[0 +: WIDTH];
            assign n_sk[0]  = bus.in_north[0 +: WIDTH];
            assign wv_sk[0] = accept;
            assign nv_sk[0] = accept;
        end else begin : g_chain
            logic signed [WIDTH-1:0] wd [gl];
            logic signed [WIDTH-1:0] nd [gl];
            logic                    wv [gl];
            logic                    nv [gl];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < gl; s++) begin
                        wd[s] <= '0;
                        nd[s] <= '0;
                        wv[s] <= 1'b0;
                        nv[s] <= 1'b0;
                    end
                end else begin
                    wd[0] <= bus.in_west[gl*WIDTH +: WIDTH];
                    nd[0] <= bus.in_north[gl*WIDTH +: WIDTH];
                    wv[0] <= accept;
                    nv[0] <= accept;
                    for (int s = 1; s < gl; s++) begin
                        wd[s] <= wd[s-1];
                        nd[s] <= nd[s-1];
                        wv[s] <= wv[s-1];
                        nv[s] <= nv[s-1];
                    end
                end
            end
            assign w_sk[gl]  = wd[gl-1];
            assign n_sk[gl]  = nd[gl-1];
            assign wv_sk[gl] = wv[gl-1];
            assign nv_sk[gl] = nv[gl-1];
        end
    end

    logic signed [WIDTH-1:0] a_fw [N][N-1];
    logic                    a_fv [N][N-1];
    logic signed [WIDTH-1:0] b_fw [N-1][N];
    logic                    b_fv [N-1][N];

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            logic signed [WIDTH-1:0]   a_op, b_op;
            logic                      a_v, b_v;
            logic signed [2*WIDTH-1:0] prod;
            logic signed [ACC_W-1:0]   acc;
            logic        [WIDTH-1:0]   res;

            if (gj == 0) begin : g_wsrc
                assign a_op = w_sk[gi];
                assign a_v  = wv_sk[gi];
            end else begin : g_wpe
                assign a_op = a_fw[gi][gj-1];
                assign a_v  = a_fv[gi][gj-1];
            end
            if (gi == 0) begin : g_nsrc
                assign b_op = n_sk[gj];
                assign b_v  = nv_sk[gj];
            end else begin : g_npe
                assign b_op = b_fw[gi-1][gj];
                assign b_v  = b_fv[gi-1][gj];
            end

            assign prod = a_op * b_op;

            always_ff @(posedge clk) begin
                if (rst || start_take) acc <= '0;
                else if (a_v && b_v)   acc <= acc + ACC_W'(prod);
            end

            always_ff @(posedge clk) begin
                if (rst)            res <= '0;
                else if (drain_end) res <= to_out(acc);
            end
            assign out_w[((N*N-1)-(gi*N+gj))*WIDTH +: WIDTH] = res;

            if (gj < N-1) begin : g_east
                always_ff @(posedge clk) begin
                    if (rst) begin
                        a_fw[gi][gj] <= '0;
                        a_fv[gi][gj] <= 1'b0;
                    end else begin
                        a_fw[gi][gj] <= a_op;
                        a_fv[gi][gj] <= a_v;
                    end
                end
            end
            if (gi < N-1) begin : g_south
                always_ff @(posedge clk) begin
                    if (rst) begin
                        b_fw[gi][gj] <= '0;
                        b_fv[gi][gj] <= 1'b0;
                    end else begin
                        b_fw[gi][gj] <= b_op;
                        b_fv[gi][gj] <= b_v;
                    end
                end
            end
        end
    end
endmodule
